// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if
//   Bundles the result-producer push ports, the registered CDB broadcast and
//   the arbiter status flags.
//   slave  : arbiter side (takes pushes, drives the CDB and flags)
//   master : environment side (ALU/LSB producers plus the CDB snoopers)
//   Signals: rdy, rollback,
//            alu_result / alu_result_rob_pos[3:0] / alu_result_val[31:0] / alu_nxt_full,
//            lsb_result / lsb_result_rob_pos[3:0] / lsb_result_val[31:0] / lsb_nxt_full,
//            cdb_valid / cdb_rob_pos[3:0] / cdb_val[31:0] / cdb_src, overflow
interface cdb_arbiter_if;
  logic        rdy;
  logic        rollback;

  logic        alu_result;
  logic [3:0]  alu_result_rob_pos;
  logic [31:0] alu_result_val;
  logic        alu_nxt_full;

  logic        lsb_result;
  logic [3:0]  lsb_result_rob_pos;
  logic [31:0] lsb_result_val;
  logic        lsb_nxt_full;

  logic        cdb_valid;
  logic [3:0]  cdb_rob_pos;
  logic [31:0] cdb_val;
  logic        cdb_src;
  logic        overflow;

  modport slave (
    input  rdy, rollback,
    input  alu_result, alu_result_rob_pos, alu_result_val,
    input  lsb_result, lsb_result_rob_pos, lsb_result_val,
    output alu_nxt_full, lsb_nxt_full,
    output cdb_valid, cdb_rob_pos, cdb_val, cdb_src, overflow
  );

  modport master (
    output rdy, rollback,
    output alu_result, alu_result_rob_pos, alu_result_val,
    output lsb_result, lsb_result_rob_pos, lsb_result_val,
    input  alu_nxt_full, lsb_nxt_full,
    input  cdb_valid, cdb_rob_pos, cdb_val, cdb_src, overflow
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Shares the common data bus between the ALU (source 0) and the LSB
//   (source 1). Each source has a DEPTH-entry circular FIFO; a round-robin
//   arbiter puts at most one {rob_pos, value} per cycle on a registered CDB.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : cdb_arbiter_if.slave (pushes, rdy/rollback, CDB, nxt_full, overflow)
//   Parameter:
//     DEPTH : entries per source FIFO (power of two, >= 2)
//   Build option:
//     CDB_ARB_BYPASS_EN : when defined, a push into an empty FIFO may be
//                         granted in the same cycle (1-cycle latency);
//                         otherwise every result goes through its FIFO.
module cdb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  cdb_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [3:0]  rob_pos;
    logic [31:0] val;
  } entry_t;

  // index 0 = ALU, index 1 = LSB throughout
  entry_t        mem [2][DEPTH];
  logic [PW-1:0] head [2];
  logic [PW-1:0] tail [2];
  logic [CW-1:0] cnt [2];
  logic [CW-1:0] cnt_nxt [2];
  entry_t        push_data [2];

  logic [1:0] push;
  logic [1:0] nonempty;
  logic [1:0] cand;
  logic [1:0] pop;
  logic [1:0] byp;
  logic [1:0] wr;
  logic [1:0] ovf;

  logic   last_grant;
  logic   active;
  logic   flush;
  logic   grant_valid;
  logic   grant_src;
  entry_t grant_entry;

  logic   cdb_valid_q;
  entry_t cdb_entry_q;
  logic   cdb_src_q;
  logic   overflow_q;

  always_comb begin
    push         = {bus.lsb_result, bus.alu_result};
    push_data[0] = {bus.alu_result_rob_pos, bus.alu_result_val};
    push_data[1] = {bus.lsb_result_rob_pos, bus.lsb_result_val};
    // rdy low freezes everything, including a pending rollback
    active = bus.rdy & ~bus.rollback;
    flush  = bus.rdy & bus.rollback;

    for (int s = 0; s < 2; s++) begin
      nonempty[s] = (cnt[s] != '0);
`ifdef CDB_ARB_BYPASS_EN
      cand[s] = active & (nonempty[s] | push[s]);
`else
      cand[s] = active & nonempty[s];
`endif
    end

    grant_valid = |cand;
    grant_src   = (&cand) ? ~last_grant : cand[1];

    for (int s = 0; s < 2; s++) begin
      pop[s] = grant_valid & (grant_src == 1'(s)) & nonempty[s];
      byp[s] = grant_valid & (grant_src == 1'(s)) & ~nonempty[s];
      // a full FIFO still accepts a push when its head leaves this cycle
      wr[s]  = active & push[s] & ~byp[s] & ((cnt[s] != FULL) | pop[s]);
      ovf[s] = active & push[s] & (cnt[s] == FULL) & ~pop[s];
      if (flush) cnt_nxt[s] = '0;
      else       cnt_nxt[s] = cnt[s] + CW'(wr[s]) - CW'(pop[s]);
    end

`ifdef CDB_ARB_BYPASS_EN
    grant_entry = nonempty[grant_src] ? mem[grant_src][head[grant_src]]
                                      : push_data[grant_src];
`else
    grant_entry = mem[grant_src][head[grant_src]];
`endif
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (wr[s]) mem[s][tail[s]] <= push_data[s];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin
        head[s] <= '0;
        tail[s] <= '0;
        cnt[s]  <= '0;
      end
      last_grant  <= 1'b1;
      cdb_valid_q <= 1'b0;
      cdb_entry_q <= '0;
      cdb_src_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (bus.rdy) begin
      overflow_q <= overflow_q | (|ovf);
      for (int s = 0; s < 2; s++) begin
        cnt[s] <= cnt_nxt[s];
        if (bus.rollback) begin
          head[s] <= '0;
          tail[s] <= '0;
        end else begin
          if (pop[s]) head[s] <= head[s] + PW'(1);
          if (wr[s])  tail[s] <= tail[s] + PW'(1);
        end
      end
      // grant_valid is forced low by rollback, which clears the broadcast
      cdb_valid_q <= grant_valid;
      if (grant_valid) begin
        last_grant  <= grant_src;
        cdb_entry_q <= grant_entry;
        cdb_src_q   <= grant_src;
      end
    end
  end

  assign bus.alu_nxt_full = (cnt_nxt[0] == FULL);
  assign bus.lsb_nxt_full = (cnt_nxt[1] == FULL);
  assign bus.cdb_valid    = cdb_valid_q;
  assign bus.cdb_rob_pos  = cdb_entry_q.rob_pos;
  assign bus.cdb_val      = cdb_entry_q.val;
  assign bus.cdb_src      = cdb_src_q;
  assign bus.overflow     = overflow_q;
endmodule
